// File: rtl/lpm_sequencer_pkg.sv
// ============================================================================
//  Module      : lpm_sequencer_pkg
//  Description : Shared state encodings, LPMCTL layout and defaults for the
//                low-power-mode sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lpm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_CPU_OFF    = 3'd1,
        ST_SMCLK_OFF  = 3'd2,
        ST_SLEEP      = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_WAKE_SMCLK = 3'd5
    } lpm_state_e;

    localparam logic [8:0] LPMCTL_DEF     = 9'h05A;
    localparam logic [3:0] SETTLE_RST_DEF = 4'h8;

    localparam int SETTLE_LSB = 0;
    localparam int SETTLE_W   = 4;
    localparam int STATE_LSB  = 4;
    localparam int STATE_W    = 3;

    function automatic logic [15:0] lpmctl_pack(input lpm_state_e st, input logic [3:0] settle);
        logic [15:0] v;
        v = 16'h0000;
        v[SETTLE_LSB +: SETTLE_W] = settle;
        v[STATE_LSB +: STATE_W]   = st;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpm_settle_cnt.sv
// ============================================================================
//  Module      : lpm_settle_cnt
//  Description : Loadable 4-bit down-counter stepped by LFXT edges; saturates
//                at zero and flags it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lpm_settle_cnt (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       count_en,
    input  logic       lfxt_edge,
    output logic       zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (count_en && lfxt_edge && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign zero = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/lpm_sequencer.sv
// ============================================================================
//  Module      : lpm_sequencer
//  Description : Sequences CPU clock enable, SCG1 and OSCOFF into and out of
//                low-power modes. Optional oscillator settle wait is built
//                when LPM_OSC_SETTLE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lpm_sequencer #(
    parameter logic [8:0] LPMCTL     = lpm_sequencer_pkg::LPMCTL_DEF,
    parameter logic [3:0] SETTLE_RST = lpm_sequencer_pkg::SETTLE_RST_DEF
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        cpuoff,
    input  logic        scg1_req,
    input  logic        oscoff_req,
    input  logic        irq_pend,
    input  logic        lfxt_edge,
    input  logic [7:0]  per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_wen,
    output logic        cpu_en,
    output logic        scg1,
    output logic        oscoff,
    output logic [15:0] per_dout
);

    import lpm_sequencer_pkg::*;

    lpm_state_e r_state;
    lpm_state_e w_state_nxt;
    logic       r_cpu_en;
    logic       r_scg1;
    logic       r_oscoff;
    logic       w_cpu_en_nxt;
    logic       w_scg1_nxt;
    logic       w_oscoff_nxt;
    logic       w_settle_load;
    logic       w_cnt_zero;
    logic [3:0] w_settle_rd;
    logic       w_match;
    logic       w_wr;
    logic       w_rd;
    logic       w_unused;

    // per_addr is a word address; the register lives at a byte address.
    assign w_match = (per_addr == LPMCTL[8:1]);
    assign w_wr    = per_en & per_wen[0] & w_match;
    assign w_rd    = per_en & ~|per_wen & w_match;

`ifdef LPM_OSC_SETTLE_EN
    logic [3:0] r_settle;

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_settle <= SETTLE_RST;
        end else if (w_wr) begin
            r_settle <= per_din[SETTLE_LSB +: SETTLE_W];
        end
    end

    // The counter holds its own copy, so a write during SETTLE leaves it alone.
    lpm_settle_cnt u_settle_cnt (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .load      (w_settle_load),
        .load_val  (r_settle),
        .count_en  (r_state == ST_SETTLE),
        .lfxt_edge (lfxt_edge),
        .zero      (w_cnt_zero)
    );

    assign w_settle_rd = r_settle;
    assign w_unused    = ^{per_din[15:4], w_wr};
`else
    assign w_cnt_zero  = 1'b1;
    assign w_settle_rd = 4'h0;
    assign w_unused    = ^{per_din, lfxt_edge, SETTLE_RST, w_wr, w_settle_load};
`endif

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_cpu_en <= 1'b1;
            r_scg1   <= 1'b0;
            r_oscoff <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_en <= w_cpu_en_nxt;
            r_scg1   <= w_scg1_nxt;
            r_oscoff <= w_oscoff_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cpu_en_nxt  = r_cpu_en;
        w_scg1_nxt    = r_scg1;
        w_oscoff_nxt  = r_oscoff;
        w_settle_load = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (cpuoff && !irq_pend) begin
                    w_state_nxt  = ST_CPU_OFF;
                    w_cpu_en_nxt = 1'b0;
                end
            end
            ST_CPU_OFF: begin
                if (irq_pend) begin
                    w_state_nxt  = ST_RUN;
                    w_cpu_en_nxt = 1'b1;
                end else if (scg1_req) begin
                    w_state_nxt = ST_SMCLK_OFF;
                    w_scg1_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            ST_SMCLK_OFF: begin
                if (irq_pend) begin
                    w_state_nxt = ST_WAKE_SMCLK;
                    w_scg1_nxt  = 1'b0;
                end else begin
                    w_state_nxt  = ST_SLEEP;
                    w_oscoff_nxt = oscoff_req;
                end
            end
            ST_SLEEP: begin
                if (irq_pend) begin
                    if (r_oscoff) begin
`ifdef LPM_OSC_SETTLE_EN
                        w_state_nxt   = ST_SETTLE;
                        w_oscoff_nxt  = 1'b0;
                        w_settle_load = 1'b1;
`else
                        w_state_nxt  = ST_WAKE_SMCLK;
                        w_oscoff_nxt = 1'b0;
                        w_scg1_nxt   = 1'b0;
`endif
                    end else if (r_scg1) begin
                        w_state_nxt = ST_WAKE_SMCLK;
                        w_scg1_nxt  = 1'b0;
                    end else begin
                        w_state_nxt  = ST_RUN;
                        w_cpu_en_nxt = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                // Wake is already committed here, so irq_pend is not consulted.
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAKE_SMCLK;
                    w_scg1_nxt  = 1'b0;
                end
            end
            ST_WAKE_SMCLK: begin
                w_state_nxt  = ST_RUN;
                w_cpu_en_nxt = 1'b1;
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_cpu_en_nxt = 1'b1;
                w_scg1_nxt   = 1'b0;
                w_oscoff_nxt = 1'b0;
            end
        endcase
    end

    assign cpu_en   = r_cpu_en;
    assign scg1     = r_scg1;
    assign oscoff   = r_oscoff;
    assign per_dout = w_rd ? lpmctl_pack(r_state, w_settle_rd) : 16'h0000;

endmodule

`default_nettype wire
